pingpong_memory_vault: RTL and testbench
========================================

// Module: pingpong_memory_vault
// PURPOSE
//  Parametrised, double-buffered successor to the NPU memory vault. NUM_BANKS parallel banks, each split into two halves.
//  The fill engine streams words into, or out of, the INACTIVE half over valid/ready.
//  Concurrently, the sweep engine reads one full row (all banks) per cycle from the ACTIVE half to feed the MAC array.
//  A swap command exchanges the halves, so weight/activation loading for layer N+1 overlaps compute of layer N.
// PARAMETERS
//  DATA_WIDTH   16   word width
//  NUM_BANKS    4    parallel banks (lanes)
//  BANK_DEPTH   256  words per half per bank (power of 2); AW = $clog2(BANK_DEPTH) localparam
// PORTS
//  clk        in  1                 single clock, all logic rising-edge
//  reset_b    in  1                 reset, asynchronous, ACTIVE-HIGH (1 = reset)
//  ld_start   in  1                 pulse: begin load into inactive half
//  ld_count   in  AW+$clog2(NB)+1   words to load/unload, 1..NUM_BANKS*BANK_DEPTH; sampled on ld_start/ul_start
//  ld_valid   in  1                 load word valid
//  ld_ready   out 1                 load word accepted when ld_valid&ld_ready
//  ld_data    in  DATA_WIDTH        load word
//  ul_start   in  1                 pulse: begin unload from inactive half
//  ul_valid   out 1                 unload word valid
//  ul_ready   in  1                 unload consumer ready
//  ul_data    out DATA_WIDTH        unload word
//  rd_start   in  1                 pulse: begin sweep of active half
//  rd_len     in  AW+1              rows to sweep, 1..BANK_DEPTH; sampled on rd_start
//  rd_valid   out 1                 row valid
//  rd_last    out 1                 final row of sweep (qualified by rd_valid)
//  rd_data    out NUM_BANKS*DW      row; bank k at [k*DW +: DW]
//  swap       in  1                 pulse: exchange active/inactive halves
//  active_half out 1                half read by sweep engine
//  fill_busy  out 1                 fill engine not IDLE
//  rd_busy    out 1                 sweep engine not IDLE
//  err        out 1                 one-cycle pulse on any rejected command
// BEHAVIOUR
//  Reset: all outputs 0 (ld_ready=0, active_half=0); both engines IDLE. Memory contents are not cleared.
//  Reset mid-operation aborts immediately; a partially written half is left as-is.
//  Storage: per bank 2*BANK_DEPTH words, address {half,row}.
//   Port A belongs to the fill engine (inactive half). Port B is sweep read-only (active half).
//   The ports never collide.
//  Word mapping (load & unload): stream index i -> bank i%NUM_BANKS, row i/NUM_BANKS.
//  Fill FSM: IDLE -> LOAD | UL_RD -> UL_HOLD -> UL_RD ... -> IDLE
//   LOAD: ld_ready=1. Each handshake writes one word and increments i. After handshake i==count-1 -> IDLE (ld_ready=0 next cycle).
//   UL_RD: issue port-A read of word i (1-cycle latency), then go to UL_HOLD.
//   UL_HOLD: ul_valid=1, ul_data held stable until ul_ready. On handshake: last word -> IDLE, else -> UL_RD.
//   Unload throughput is 1 word / 2 cycles; first ul_valid appears 2 cycles after ul_start.
//  Sweep FSM: IDLE -> SWEEP -> IDLE. Row r (0..len-1) is read at cycle r after rd_start.
//   rd_valid/rd_data appear 1 cycle later; rd_last accompanies row len-1.
//   No backpressure. rd_start to first rd_valid = 2 cycles.
//   rd_busy stays high until the cycle that presents rd_last.
//  Swap: accepted only when both engines IDLE; toggles active_half next cycle.
//   If swap and ld_start/ul_start/rd_start arrive in the same cycle, swap takes effect first.
//   The start command then targets the NEW halves.
//  Rejected (err=1, no state change):
//   - ld_start/ul_start while fill_busy
//   - rd_start while rd_busy
//   - ld_count==0 or ld_count>NUM_BANKS*BANK_DEPTH
//   - rd_len==0 or rd_len>BANK_DEPTH
//   - swap while either engine busy
//   - ld_start and ul_start in the same cycle (both rejected)
//  Concurrency: a load/unload and a sweep run simultaneously at full rate.
//   ld_valid is ignored unless in LOAD.
// TESTING
//  1. NB=4, DEPTH=256. Load 8 words 0x10..0x17; swap; rd_start len=2
//     -> rows {0x13,0x12,0x11,0x10}, {0x17,0x16,0x15,0x14}; rd_last on the 2nd row.
//  2. Load 1024 words into half 1 while sweeping 256 rows of half 0
//     -> sweep data equals prior half-0 contents; no err; load completes in 1024 handshakes.
//  3. Unload 5 words with ul_ready toggled randomly -> ul_data stable while ul_valid&!ul_ready; order matches load order.
//  4. Swap during sweep; ld_count=0; rd_len=257 -> err pulse each time; active_half and engine states unchanged.
//  5. Swap+rd_start in the same cycle -> sweep reads the newly active half.
//  6. Assert reset_b mid-load after 3 words -> ld_ready=0 and fill_busy=0 in the same cycle.
//     A new load after release completes normally.

Source files
------------

// File: rtl/pingpong_memory_vault.sv
// pingpong_memory_vault: double-buffered multi-bank word store.
// Each bank holds two halves addressed as {half,row}. The fill engine
// streams words into, or out of, the inactive half over valid/ready while
// the sweep engine reads one full row (all banks) per cycle from the
// active half. A swap exchanges the halves once both engines are idle.
// NUM_BANKS and BANK_DEPTH must be powers of two, NUM_BANKS >= 2.
//
// Fill FSM
//   state     | meaning
//   F_IDLE    | waiting for ld_start / ul_start
//   F_LOAD    | ld_ready high, one word written per handshake
//   F_UL_RD   | port-A read of the next unload word issued
//   F_UL_HOLD | ul_valid high, ul_data held until ul_ready
//
// Sweep FSM
//   state     | meaning
//   S_IDLE    | waiting for rd_start
//   S_SWEEP   | one row read per cycle, result presented next cycle

module pingpong_memory_vault #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_BANKS  = 4,
   parameter int BANK_DEPTH = 256
) (
   input  logic                                          clk,
   input  logic                                          reset_b,
   input  logic                                          ld_start,
   input  logic [$clog2(BANK_DEPTH)+$clog2(NUM_BANKS):0] ld_count,
   input  logic                                          ld_valid,
   output logic                                          ld_ready,
   input  logic [DATA_WIDTH-1:0]                         ld_data,
   input  logic                                          ul_start,
   output logic                                          ul_valid,
   input  logic                                          ul_ready,
   output logic [DATA_WIDTH-1:0]                         ul_data,
   input  logic                                          rd_start,
   input  logic [$clog2(BANK_DEPTH):0]                   rd_len,
   output logic                                          rd_valid,
   output logic                                          rd_last,
   output logic [NUM_BANKS*DATA_WIDTH-1:0]               rd_data,
   input  logic                                          swap,
   output logic                                          active_half,
   output logic                                          fill_busy,
   output logic                                          rd_busy,
   output logic                                          err
);

   localparam int DW  = DATA_WIDTH;
   localparam int AW  = $clog2(BANK_DEPTH);
   localparam int NBW = $clog2(NUM_BANKS);
   localparam int CW  = AW + NBW + 1;

   localparam logic [CW-1:0] MAX_WORDS = CW'(NUM_BANKS * BANK_DEPTH);
   localparam logic [AW:0]   MAX_ROWS  = (AW+1)'(BANK_DEPTH);

   typedef enum logic [1:0] {F_IDLE, F_LOAD, F_UL_RD, F_UL_HOLD} fill_state_t;
   typedef enum logic       {S_IDLE, S_SWEEP} sweep_state_t;

   fill_state_t  fill_state;
   sweep_state_t sweep_state;

   logic [CW-1:0] fill_idx;
   logic [CW-1:0] fill_left;
   logic [AW-1:0] sweep_row;
   logic [AW:0]   sweep_left;

   logic fill_idle, sweep_idle;
   logic count_ok, len_ok;
   logic ld_ok, ul_ok, rd_ok, swap_ok, any_reject;

   logic [NBW-1:0] a_bank;
   logic [AW-1:0]  a_row;
   logic [AW:0]    a_addr;
   logic [AW:0]    b_addr;
   logic           a_we, a_re, b_re;

   logic [DW-1:0] mem [NUM_BANKS][2*BANK_DEPTH];

   // command qualification; a start with a bad length or a busy engine is dropped
   assign fill_idle  = (fill_state == F_IDLE);
   assign sweep_idle = (sweep_state == S_IDLE);
   assign count_ok   = (ld_count != '0) && (ld_count <= MAX_WORDS);
   assign len_ok     = (rd_len != '0) && (rd_len <= MAX_ROWS);

   assign ld_ok   = ld_start & ~ul_start & fill_idle & count_ok;
   assign ul_ok   = ul_start & ~ld_start & fill_idle & count_ok;
   assign rd_ok   = rd_start & sweep_idle & len_ok;
   assign swap_ok = swap & fill_idle & sweep_idle;

   assign any_reject = (ld_start & ~ld_ok) | (ul_start & ~ul_ok) |
                       (rd_start & ~rd_ok) | (swap & ~swap_ok);

   // stream index i maps to bank i%NB, row i/NB; engines always use the
   // current half, so a start accepted together with a swap sees the new halves
   assign a_bank = fill_idx[NBW-1:0];
   assign a_row  = fill_idx[NBW +: AW];
   assign a_addr = {~active_half, a_row};
   assign b_addr = {active_half, sweep_row};

   assign a_we = ld_valid & ld_ready;
   assign a_re = (fill_state == F_UL_RD);
   assign b_re = (sweep_state == S_SWEEP);

   // port A write (fill engine, inactive half); contents survive reset
   always_ff @(posedge clk) begin
      if (a_we) mem[a_bank][a_addr] <= ld_data;
   end

   // port A read register; only updated in UL_RD so it is stable through UL_HOLD
   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b)   ul_data <= '0;
      else if (a_re) ul_data <= mem[a_bank][a_addr];
   end

   // port B: one read register per bank forms the presented row
   for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
      logic [DW-1:0] b_q;

      // row read of this bank from the active half
      always_ff @(posedge clk or posedge reset_b) begin
         if (reset_b)   b_q <= '0;
         else if (b_re) b_q <= mem[k][b_addr];
      end

      assign rd_data[k*DW +: DW] = b_q;
   end

   // fill engine: load or unload of the inactive half
   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         fill_state <= F_IDLE;
         fill_idx   <= '0;
         fill_left  <= '0;
         ld_ready   <= 1'b0;
         ul_valid   <= 1'b0;
         fill_busy  <= 1'b0;
      end else begin
         case (fill_state)
            F_IDLE: begin
               if (ld_ok) begin
                  fill_state <= F_LOAD;
                  ld_ready   <= 1'b1;
                  fill_busy  <= 1'b1;
                  fill_idx   <= '0;
                  fill_left  <= ld_count;
               end else if (ul_ok) begin
                  fill_state <= F_UL_RD;
                  fill_busy  <= 1'b1;
                  fill_idx   <= '0;
                  fill_left  <= ld_count;
               end
            end
            F_LOAD: begin
               if (ld_valid) begin
                  if (fill_left == CW'(1)) begin
                     fill_state <= F_IDLE;
                     ld_ready   <= 1'b0;
                     fill_busy  <= 1'b0;
                  end else begin
                     fill_idx  <= fill_idx + CW'(1);
                     fill_left <= fill_left - CW'(1);
                  end
               end
            end
            F_UL_RD: begin
               fill_state <= F_UL_HOLD;
               ul_valid   <= 1'b1;
            end
            F_UL_HOLD: begin
               if (ul_ready) begin
                  ul_valid <= 1'b0;
                  if (fill_left == CW'(1)) begin
                     fill_state <= F_IDLE;
                     fill_busy  <= 1'b0;
                  end else begin
                     fill_state <= F_UL_RD;
                     fill_idx   <= fill_idx + CW'(1);
                     fill_left  <= fill_left - CW'(1);
                  end
               end
            end
            default: begin
               fill_state <= F_IDLE;
               ld_ready   <= 1'b0;
               ul_valid   <= 1'b0;
               fill_busy  <= 1'b0;
            end
         endcase
      end
   end

   // sweep engine: one row per cycle from the active half, no backpressure;
   // rd_busy drops in the cycle that presents rd_last
   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         sweep_state <= S_IDLE;
         sweep_row   <= '0;
         sweep_left  <= '0;
         rd_valid    <= 1'b0;
         rd_last     <= 1'b0;
         rd_busy     <= 1'b0;
      end else begin
         case (sweep_state)
            S_IDLE: begin
               rd_valid <= 1'b0;
               rd_last  <= 1'b0;
               if (rd_ok) begin
                  sweep_state <= S_SWEEP;
                  sweep_row   <= '0;
                  sweep_left  <= rd_len;
                  rd_busy     <= 1'b1;
               end
            end
            S_SWEEP: begin
               rd_valid <= 1'b1;
               rd_last  <= (sweep_left == (AW+1)'(1));
               if (sweep_left == (AW+1)'(1)) begin
                  sweep_state <= S_IDLE;
                  rd_busy     <= 1'b0;
               end else begin
                  sweep_row  <= sweep_row + AW'(1);
                  sweep_left <= sweep_left - (AW+1)'(1);
               end
            end
            default: begin
               sweep_state <= S_IDLE;
               rd_valid    <= 1'b0;
               rd_last     <= 1'b0;
               rd_busy     <= 1'b0;
            end
         endcase
      end
   end

   // half selection and the rejected-command pulse
   always_ff @(posedge clk or posedge reset_b) begin
      if (reset_b) begin
         active_half <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (swap_ok) active_half <= ~active_half;
         err <= any_reject;
      end
   end

endmodule

// File: tb/tb_pingpong_memory_vault.sv
// Bench for pingpong_memory_vault: directed sequences with a reference
// word model; expected rows and unload words are queued at issue time and
// a negedge monitor pops and compares them as the DUT presents them.

module tb_pingpong_memory_vault;

   localparam int DW    = 16;
   localparam int NB    = 4;
   localparam int DEPTH = 256;
   localparam int CW    = 11;
   localparam int LW    = 9;

   logic            clk;
   logic            reset_b;
   logic            ld_start;
   logic [CW-1:0]   ld_count;
   logic            ld_valid;
   logic            ld_ready;
   logic [DW-1:0]   ld_data;
   logic            ul_start;
   logic            ul_valid;
   logic            ul_ready;
   logic [DW-1:0]   ul_data;
   logic            rd_start;
   logic [LW-1:0]   rd_len;
   logic            rd_valid;
   logic            rd_last;
   logic [NB*DW-1:0] rd_data;
   logic            swap;
   logic            active_half;
   logic            fill_busy;
   logic            rd_busy;
   logic            err;

   pingpong_memory_vault #(.DATA_WIDTH(DW), .NUM_BANKS(NB), .BANK_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_b(reset_b),
      .ld_start(ld_start), .ld_count(ld_count), .ld_valid(ld_valid),
      .ld_ready(ld_ready), .ld_data(ld_data),
      .ul_start(ul_start), .ul_valid(ul_valid), .ul_ready(ul_ready), .ul_data(ul_data),
      .rd_start(rd_start), .rd_len(rd_len), .rd_valid(rd_valid), .rd_last(rd_last),
      .rd_data(rd_data), .swap(swap), .active_half(active_half),
      .fill_busy(fill_busy), .rd_busy(rd_busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [NB*DW-1:0] data;
      logic             last;
   } row_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          err_seen = 0;
   int          err_exp  = 0;
   logic [DW-1:0] ref_mem [2][NB*DEPTH];
   logic        exp_half;
   row_t        exp_rd[$];
   logic [DW-1:0] exp_ul[$];
   logic        prev_hold;
   logic [DW-1:0] prev_ul;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // monitor: rows, unload words, hold stability and err pulses
   always @(negedge clk) begin
      row_t e;
      if (reset_b) begin
         prev_hold = 1'b0;
      end else begin
         if (err) err_seen++;
         if (rd_valid) begin
            chk("rd_expected", 64'(exp_rd.size() != 0), 64'(1));
            if (exp_rd.size() != 0) begin
               e = exp_rd.pop_front();
               chk("rd_data", rd_data, e.data);
               chk("rd_last", 64'(rd_last), 64'(e.last));
               chk("rd_busy_row", 64'(rd_busy), 64'(!e.last));
            end
         end
         if (ul_valid) begin
            if (prev_hold) chk("ul_stable", 64'(ul_data), 64'(prev_ul));
            if (ul_ready) begin
               chk("ul_expected", 64'(exp_ul.size() != 0), 64'(1));
               if (exp_ul.size() != 0) chk("ul_data", 64'(ul_data), 64'(exp_ul.pop_front()));
            end
         end
         prev_hold = ul_valid & ~ul_ready;
         prev_ul   = ul_data;
      end
   end

   task automatic do_load(input int n, input logic [DW-1:0] base, input int stop_after, input int gap);
      int   i = 0;
      int   budget = 4 * n + 20;
      logic hs;
      logic h = ~exp_half;
      ld_start = 1'b1;
      ld_count = CW'(n);
      tick();
      ld_start = 1'b0;
      while (i < n && budget > 0) begin
         ld_valid = (gap == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
         ld_data  = base + DW'(i);
         @(negedge clk);
         hs = ld_ready & ld_valid;
         tick();
         budget--;
         if (hs) begin
            ref_mem[h][i] = ld_data;
            i++;
            if (i == stop_after) return;
         end
      end
      ld_valid = 1'b0;
      chk("ld_handshakes", 64'(i), 64'(n));
      @(negedge clk);
      chk("ld_ready_after", 64'(ld_ready), 64'(0));
      chk("ld_fill_busy_after", 64'(fill_busy), 64'(0));
   endtask

   task automatic push_rows(input int len);
      row_t e;
      for (int r = 0; r < len; r++) begin
         e.data = '0;
         for (int k = 0; k < NB; k++) e.data[k*DW +: DW] = ref_mem[exp_half][r*NB + k];
         e.last = (r == len - 1);
         exp_rd.push_back(e);
      end
   endtask

   task automatic wait_rd_drain(input int budget);
      int b = budget;
      while (exp_rd.size() != 0 && b > 0) begin
         tick();
         b--;
      end
      chk("rd_drain", 64'(exp_rd.size()), 64'(0));
      @(negedge clk);
      chk("rd_busy_end", 64'(rd_busy), 64'(0));
   endtask

   task automatic do_sweep(input int len, input logic with_swap);
      if (with_swap) begin
         swap     = 1'b1;
         exp_half = ~exp_half;
      end
      push_rows(len);
      rd_start = 1'b1;
      rd_len   = LW'(len);
      tick();
      rd_start = 1'b0;
      swap     = 1'b0;
      @(negedge clk);
      chk("rd_latency_early", 64'(rd_valid), 64'(0));
      tick();
      @(negedge clk);
      chk("rd_latency", 64'(rd_valid), 64'(1));
      wait_rd_drain(len + 10);
   endtask

   task automatic do_swap();
      swap = 1'b1;
      tick();
      swap     = 1'b0;
      exp_half = ~exp_half;
      @(negedge clk);
      chk("swap_half", 64'(active_half), 64'(exp_half));
   endtask

   task automatic do_unload(input int n);
      int   budget = 20 * n + 20;
      logic h = ~exp_half;
      for (int i = 0; i < n; i++) exp_ul.push_back(ref_mem[h][i]);
      ul_ready = 1'b0;
      ul_start = 1'b1;
      ld_count = CW'(n);
      tick();
      ul_start = 1'b0;
      @(negedge clk);
      chk("ul_latency_early", 64'(ul_valid), 64'(0));
      tick();
      @(negedge clk);
      chk("ul_latency", 64'(ul_valid), 64'(1));
      tick();
      while (exp_ul.size() != 0 && budget > 0) begin
         ul_ready = ($urandom_range(0, 1) != 0);
         tick();
         budget--;
      end
      ul_ready = 1'b0;
      chk("ul_drain", 64'(exp_ul.size()), 64'(0));
      @(negedge clk);
      chk("ul_fill_busy_end", 64'(fill_busy), 64'(0));
   endtask

   // caller has already driven the offending command
   task automatic reject(input string name, input logic exp_fb, input logic exp_rb);
      err_exp++;
      tick();
      ld_start = 1'b0;
      ul_start = 1'b0;
      rd_start = 1'b0;
      swap     = 1'b0;
      @(negedge clk);
      chk(name, 64'(err), 64'(1));
      chk({name, "_fill_busy"}, 64'(fill_busy), 64'(exp_fb));
      chk({name, "_rd_busy"}, 64'(rd_busy), 64'(exp_rb));
      chk({name, "_half"}, 64'(active_half), 64'(exp_half));
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_b  = 1'b1;
      ld_start = 1'b0; ld_count = '0; ld_valid = 1'b0; ld_data = '0;
      ul_start = 1'b0; ul_ready = 1'b0;
      rd_start = 1'b0; rd_len = '0; swap = 1'b0;
      exp_half = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      reset_b = 1'b0;
      @(negedge clk);
      chk("rst_ld_ready", 64'(ld_ready), 64'(0));
      chk("rst_ul_valid", 64'(ul_valid), 64'(0));
      chk("rst_rd_valid", 64'(rd_valid), 64'(0));
      chk("rst_rd_last", 64'(rd_last), 64'(0));
      chk("rst_active_half", 64'(active_half), 64'(0));
      chk("rst_fill_busy", 64'(fill_busy), 64'(0));
      chk("rst_rd_busy", 64'(rd_busy), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_rd_data", rd_data, 64'(0));
      chk("rst_ul_data", 64'(ul_data), 64'(0));
      tick();

      // small load into half 1, swap, sweep two rows
      do_load(8, 16'h0010, -1, 1);
      do_swap();
      do_sweep(2, 1'b0);

      // fill half 0 completely, make it active
      do_load(NB*DEPTH, 16'h1000, -1, 0);
      do_swap();

      // full load of half 1 concurrent with full sweep of half 0
      fork
         do_load(NB*DEPTH, 16'h2000, -1, 0);
         do_sweep(DEPTH, 1'b0);
      join
      chk("no_err_concurrent", 64'(err_seen), 64'(err_exp));

      // unload with random consumer backpressure
      do_unload(5);

      // rejected commands
      push_rows(4);
      rd_start = 1'b1; rd_len = LW'(4);
      tick();
      rd_start = 1'b0;
      swap = 1'b1;
      reject("err_swap_busy", 1'b0, 1'b1);
      rd_start = 1'b1; rd_len = LW'(1);
      reject("err_rd_busy", 1'b0, 1'b1);
      wait_rd_drain(20);
      ld_start = 1'b1; ld_count = CW'(0);
      reject("err_count_zero", 1'b0, 1'b0);
      rd_start = 1'b1; rd_len = LW'(257);
      reject("err_len_257", 1'b0, 1'b0);
      ul_start = 1'b1; ld_count = CW'(1025);
      reject("err_count_1025", 1'b0, 1'b0);
      ld_start = 1'b1; ul_start = 1'b1; ld_count = CW'(4);
      reject("err_ld_ul_both", 1'b0, 1'b0);

      // swap and rd_start together: sweep reads the newly active half
      do_sweep(2, 1'b1);

      // reset in the middle of a load, then a clean load and check
      do_load(8, 16'h0040, 3, 0);
      #2;
      reset_b = 1'b1;
      #1;
      chk("rst_mid_ld_ready", 64'(ld_ready), 64'(0));
      chk("rst_mid_fill_busy", 64'(fill_busy), 64'(0));
      chk("rst_mid_half", 64'(active_half), 64'(0));
      exp_half = 1'b0;
      ld_valid = 1'b0;
      @(negedge clk);
      reset_b = 1'b0;
      tick();
      do_load(8, 16'h0050, -1, 1);
      do_swap();
      do_sweep(2, 1'b0);

      chk("err_count", 64'(err_seen), 64'(err_exp));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
